// File: rtl/axis_dot_accumulator_pkg.sv
// axis_dot_accumulator_pkg: shared state encoding and default widths for the dot-product stages
package axis_dot_accumulator_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ACC_W = 72;
  localparam int DEF_CNT_W = 8;
  localparam int CNT_MAX = (1 << DEF_CNT_W) - 1;
endpackage

// File: rtl/axis_dot_accumulator.sv
// axis_dot_accumulator: sums an AXI-Stream of unsigned products into one result per tlast-terminated vector
module axis_dot_accumulator
  import axis_dot_accumulator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              m_tvalid,
  output logic [ACC_W-1:0]  m_tdata,
  output logic [CNT_W-1:0]  m_tcount,
  output logic              m_tovf,
  input  logic              m_tready
);
  state_t state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [ACC_W:0] sum;
  logic ovf, sat, ovf_nx, accept;
  // acc/cnt/ovf are always clear in HOLD, so one datapath serves both states
  assign s_tready = reset & ((state == ACCUM) | m_tready);
  assign accept = s_tvalid & s_tready;
  assign sum = {1'b0, acc} + (ACC_W + 1)'(s_tdata);
  assign sat = cnt == '1;
  assign cnt_nx = sat ? cnt : cnt + CNT_W'(1);
  assign ovf_nx = ovf | sum[ACC_W] | sat;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tcount <= '0;
      m_tovf <= 1'b0;
    end else if (accept && s_tlast) begin
      m_tdata <= sum[ACC_W-1:0];
      m_tcount <= cnt_nx;
      m_tovf <= ovf_nx;
      m_tvalid <= 1'b1;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      state <= HOLD;
    end else if (accept) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt_nx;
      ovf <= ovf_nx;
      m_tvalid <= 1'b0;
      state <= ACCUM;
    end else if (state == HOLD && m_tready) begin
      m_tvalid <= 1'b0;
      state <= ACCUM;
    end
endmodule

// File: tb/tb_axis_dot_accumulator.sv
// tb_axis_dot_accumulator: directed and randomized checks against a sum-of-terms reference model
module tb_axis_dot_accumulator;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s_tvalid = 1'b0;
  logic [63:0] s_tdata = '0;
  logic s_tlast = 1'b0;
  logic s_tready;
  logic m_tvalid;
  logic [71:0] m_tdata;
  logic [7:0] m_tcount;
  logic m_tovf;
  logic m_tready = 1'b0;
  typedef struct packed {logic [71:0] d; logic [7:0] c; logic o;} res_t;
  res_t exp_q[$], act_q[$];
  logic [127:0] m_sum = '0;
  int m_n = 0;
  int checks = 0, errors = 0;
  bit last_acc;

  axis_dot_accumulator dut (
    .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tcount(m_tcount),
    .m_tovf(m_tovf), .m_tready(m_tready)
  );

  always #5 clk = ~clk;

  // reference: a vector is a list of terms; result = sum mod 2^72, count capped at 255, flag if either limit hit
  task automatic tick();
    #1;
    last_acc = s_tvalid & s_tready;
    if (m_tvalid & m_tready) act_q.push_back('{m_tdata, m_tcount, m_tovf});
    if (!reset) begin
      m_sum = '0;
      m_n = 0;
    end else if (last_acc) begin
      m_sum += 128'(s_tdata);
      m_n++;
      if (s_tlast) begin
        exp_q.push_back('{m_sum[71:0], (m_n > 255) ? 8'hFF : 8'(m_n), (m_n > 255) || (m_sum[127:72] != 0)});
        m_sum = '0;
        m_n = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got %b want 0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %b want 0", m_tvalid); end
    checks++; if (m_tdata !== 72'd0 || m_tcount !== 8'd0 || m_tovf !== 1'b0) begin
      errors++; $display("FAIL rst_outputs got %h/%0d/%b want 0/0/0", m_tdata, m_tcount, m_tovf); end
    reset = 1'b1;
    tick();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_release_s_tready got %b want 1", s_tready); end
  endtask

  task automatic test_basic();
    logic [63:0] v[3] = '{64'd10, 64'd20, 64'd30};
    exp_q.delete(); act_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = v[i]; s_tlast = (i == 2);
      tick();
      if (i == 1) begin
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", m_tvalid); end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", m_tvalid); end
    checks++; if (m_tdata !== 72'd60 || m_tcount !== 8'd3 || m_tovf !== 1'b0) begin
      errors++; $display("FAIL basic_result got %0d/%0d/%b want 60/3/0", m_tdata, m_tcount, m_tovf); end
    tick();
    checks++; if (act_q.size() != 1 || exp_q.size() != 1 || act_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL basic_model got %0d results want %0d matching", act_q.size(), exp_q.size()); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL basic_drop got %b want 0", m_tvalid); end
  endtask

  task automatic test_backpressure();
    logic [63:0] v[3] = '{64'd10, 64'd20, 64'd30};
    exp_q.delete(); act_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = v[i]; s_tlast = (i == 2);
      tick();
    end
    m_tready = 1'b0; s_tdata = 64'd7; s_tlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 72'd60 || s_tready !== 1'b0 || last_acc) begin
        errors++; $display("FAIL bp_stall cyc %0d got valid=%b data=%0d s_tready=%b acc=%b want 1/60/0/0", i, m_tvalid, m_tdata, s_tready, last_acc); end
    end
    m_tready = 1'b1;
    tick();
    checks++; if (!last_acc || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL bp_release got acc=%b valid=%b want 1/0", last_acc, m_tvalid); end
    s_tdata = 64'd8; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tdata !== 72'd15 || m_tcount !== 8'd2 || m_tovf !== 1'b0) begin
      errors++; $display("FAIL bp_next got %0d/%0d/%b want 15/2/0", m_tdata, m_tcount, m_tovf); end
    tick();
    checks++; if (act_q.size() != 2 || exp_q.size() != 2 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL bp_model got %0d results want %0d matching", act_q.size(), exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v[3] = '{64'd5, 64'd7, 64'd9};
    exp_q.delete(); act_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = v[i]; s_tlast = 1'b1;
      tick();
      checks++; if (!last_acc || m_tvalid !== 1'b1 || m_tdata !== 72'(v[i]) || m_tcount !== 8'd1) begin
        errors++; $display("FAIL b2b_%0d got acc=%b valid=%b data=%0d cnt=%0d want 1/1/%0d/1", i, last_acc, m_tvalid, m_tdata, m_tcount, v[i]); end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tick();
    checks++; if (act_q.size() != 3 || exp_q.size() != 3 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1] || act_q[2] !== exp_q[2]) begin
      errors++; $display("FAIL b2b_model got %0d results want %0d matching", act_q.size(), exp_q.size()); end
  endtask

  task automatic test_overflow();
    exp_q.delete(); act_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      s_tvalid = 1'b1; s_tdata = '1; s_tlast = (i == 255);
      tick();
    end
    checks++; if (m_tdata !== 72'hFF_FFFF_FFFF_FFFF_FF00 || m_tcount !== 8'd255 || m_tovf !== 1'b1) begin
      errors++; $display("FAIL ovf_result got %h/%0d/%b want ff_ffff_ffff_ffff_ff00/255/1", m_tdata, m_tcount, m_tovf); end
    checks++; if (exp_q.size() != 1 || {m_tdata, m_tcount, m_tovf} !== exp_q[0]) begin
      errors++; $display("FAIL ovf_model got %h/%0d/%b want model", m_tdata, m_tcount, m_tovf); end
    s_tdata = 64'd3;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tdata !== 72'd3 || m_tcount !== 8'd1 || m_tovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %0d/%0d/%b want 3/1/0", m_tdata, m_tcount, m_tovf); end
    tick();
  endtask

  task automatic test_reset_mid();
    exp_q.delete(); act_q.delete();
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 64'd100; s_tlast = 1'b0;
    tick();
    s_tdata = 64'd200;
    tick();
    s_tvalid = 1'b0; reset = 1'b0;
    tick();
    checks++; if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_held got s_tready=%b valid=%b want 0/0", s_tready, m_tvalid); end
    reset = 1'b1;
    s_tvalid = 1'b1; s_tdata = 64'd4; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 72'd4 || m_tcount !== 8'd1) begin
      errors++; $display("FAIL rstmid_result got %b/%0d/%0d want 1/4/1", m_tvalid, m_tdata, m_tcount); end
    tick();
    checks++; if (act_q.size() != 1 || exp_q.size() != 1 || act_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL rstmid_model got %0d results want %0d matching", act_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    int n;
    exp_q.delete(); act_q.delete();
    repeat (600) begin
      if (!s_tvalid && $urandom_range(3) != 0) begin
        s_tvalid = 1'b1;
        s_tdata = ($urandom_range(7) == 0) ? '1 : {$urandom, $urandom};
        s_tlast = $urandom_range(3) == 0;
      end
      m_tready = $urandom_range(3) != 0;
      tick();
      if (last_acc) s_tvalid = 1'b0;
    end
    m_tready = 1'b1;
    for (int i = 0; i < 4 && s_tvalid; i++) begin
      tick();
      if (last_acc) s_tvalid = 1'b0;
    end
    checks++; if (s_tvalid) begin errors++; $display("FAIL rand_drain got pending=1 want 0"); end
    s_tvalid = 1'b1; s_tdata = 64'd1; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (2) tick();
    checks++; if (act_q.size() != exp_q.size() || act_q.size() < 20) begin
      errors++; $display("FAIL rand_count got %0d results want %0d (>=20)", act_q.size(), exp_q.size()); end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_res_%0d got %h/%0d/%b want %h/%0d/%b", i, act_q[i].d, act_q[i].c, act_q[i].o, exp_q[i].d, exp_q[i].c, exp_q[i].o); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
